// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
// ---------------
// Round-robin controller that shares one UART transmit core among N_REQ
// byte-stream requesters. The owner keeps the core for a whole packet, which
// ends on req_last or after MAX_BURST bytes (0 = no burst limit). Each byte is
// handed to the core with a one-cycle tx_start pulse, and the arbiter then waits
// for tx_busy to fall.
//
// Build option: define UART_ARB_SRCTAG_EN to send a source header byte
// {4'hA, 1'b0, grant_id[2:0]} at the start of every grant. The header does not
// count toward the burst limit. Without the macro no header is sent.
//
// Ports:
//   clk            system clock
//   nrst           synchronous active-low reset
//   i_req_valid    [N_REQ]    requester i offers the byte i_req_data[8i+7:8i]
//   i_req_data     [8*N_REQ]  packed request bytes
//   i_req_last     [N_REQ]    byte offered by requester i ends its packet
//   o_req_ready    [N_REQ]    one-hot accept; a byte moves when valid & ready
//   o_tx_start     one-cycle pulse: the core must send o_tx_data
//   o_tx_data      [8]        byte for the core, stable until tx_busy falls
//   i_tx_busy      the core is sending a frame
//   o_grant_valid  a requester owns the core
//   o_grant_id     [ID_W]     index of the owner
//   o_busy         the arbiter is not idle
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    output logic               o_grant_valid,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_TX
    } state_t;

    state_t          r_state;
    logic            r_grant_valid;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_rr_ptr;
    logic [7:0]      r_burst_cnt;
    logic [7:0]      r_tx_data;
    logic            r_last_q;
    logic            r_guard;

    state_t          w_state_next;
    logic            w_grant_valid_next;
    logic [ID_W-1:0] w_grant_id_next;
    logic [ID_W-1:0] w_rr_ptr_next;
    logic [7:0]      w_burst_cnt_next;
    logic [7:0]      w_tx_data_next;
    logic            w_last_q_next;
    logic            w_guard_next;

    logic            w_sel_found;
    logic [ID_W-1:0] w_sel_id;
    logic [ID_W-1:0] w_cand;
    logic            w_release;
    logic [ID_W-1:0] w_owner_next_ptr;

    // Search order starts at rr_ptr, so the last released requester is
    // visited last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_sel_found && i_req_valid[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_cand;
            end
        end
    end

    assign w_owner_next_ptr = (int'(r_grant_id) == N_REQ - 1) ? '0 : r_grant_id + 1'b1;

    // Last byte and burst limit on the same byte are one release: both only
    // feed this single condition.
    assign w_release = r_last_q ||
                       ((MAX_BURST != 0) && (int'(r_burst_cnt) == MAX_BURST));

    always_comb begin
        w_state_next       = r_state;
        w_grant_valid_next = r_grant_valid;
        w_grant_id_next    = r_grant_id;
        w_rr_ptr_next      = r_rr_ptr;
        w_burst_cnt_next   = r_burst_cnt;
        w_tx_data_next     = r_tx_data;
        w_last_q_next      = r_last_q;
        w_guard_next       = r_guard;
        o_req_ready        = '0;
        o_tx_start         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_grant_id_next    = w_sel_id;
                    w_grant_valid_next = 1'b1;
                    w_burst_cnt_next   = 8'd0;
`ifdef UART_ARB_SRCTAG_EN
                    w_state_next       = ST_TAG;
`else
                    w_state_next       = ST_FETCH;
`endif
                end
            end
`ifdef UART_ARB_SRCTAG_EN
            ST_TAG: begin
                // last_q stays clear so the header never ends the grant.
                w_tx_data_next = {4'hA, 1'b0, 3'(r_grant_id)};
                w_last_q_next  = 1'b0;
                w_state_next   = ST_ISSUE;
            end
`endif
            ST_FETCH: begin
                // An owner that pauses keeps the grant indefinitely.
                o_req_ready[r_grant_id] = i_req_valid[r_grant_id];
                if (i_req_valid[r_grant_id]) begin
                    w_tx_data_next = i_req_data[{r_grant_id, 3'b000} +: 8];
                    w_last_q_next  = i_req_last[r_grant_id];
                    if (r_burst_cnt != 8'hFF) begin
                        w_burst_cnt_next = r_burst_cnt + 8'd1;
                    end
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_tx_start   = 1'b1;
                w_guard_next = 1'b1;
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // The core may raise tx_busy one cycle late, so the first
                // cycle here ignores it.
                if (r_guard) begin
                    w_guard_next = 1'b0;
                end else if (!i_tx_busy) begin
                    if (w_release) begin
                        w_grant_valid_next = 1'b0;
                        w_rr_ptr_next      = w_owner_next_ptr;
                        w_state_next       = ST_IDLE;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_burst_cnt   <= 8'd0;
            r_tx_data     <= 8'h00;
            r_last_q      <= 1'b0;
            r_guard       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant_valid <= w_grant_valid_next;
            r_grant_id    <= w_grant_id_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_tx_data     <= w_tx_data_next;
            r_last_q      <= w_last_q_next;
            r_guard       <= w_guard_next;
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter. Requesters are fed from per-requester byte
// queues, a simple core model answers tx_start with a tx_busy window, and a
// packet-level round-robin model predicts the byte sequence on tx_start.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int MB    = 16;
    localparam int DEPTH = 128;

    logic           clk;
    logic           nrst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           busy;

    uart_tx_arbiter #(.N_REQ(N), .ID_W(IDW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .i_req_last   (req_last),
        .o_req_ready  (req_ready),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_tx_busy    (tx_busy),
        .o_grant_valid(grant_valid),
        .o_grant_id   (grant_id),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic           tag;
        logic [IDW-1:0] id;
        logic [7:0]     data;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       dlog[$];
    ent_t       flog[$];
    logic [8:0] src_mem [N][DEPTH];
    int         src_rd [N];
    int         src_wr [N];
    int         mdl_rd [N];
    logic [N-1:0] hold;
    int         m_rr;
    int         checks;
    int         errors;
    int         n_starts;
    logic [N-1:0] xfer_mask;
    logic       start_seen;
    logic       rst_seen;
    logic [7:0] last_tx;
    int         busy_len;
    int         busy_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input int idx, input int exp_id, input int exp_data);
        if (idx < dlog.size()) begin
            chk({name, "_id"}, 32'(dlog[idx].id), exp_id);
            chk({name, "_data"}, 32'(dlog[idx].data), exp_data);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: byte %0d missing, only %0d data bytes sent", name, idx, dlog.size());
        end
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic l);
        src_mem[id][src_wr[id]] = {l, d};
        src_wr[id]++;
    endtask

    function automatic bit src_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) e = 1'b0;
        end
        return e;
    endfunction

    // Packet-level model: whole packets from requesters chosen round-robin,
    // each cut at last or at MB bytes, with the released requester moved to
    // the back of the search order.
    task automatic model_run();
        int   pick;
        int   cnt;
        bit   done;
        logic [8:0] e;
        ent_t t;
        forever begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (pick < 0 && mdl_rd[c] < src_wr[c]) pick = c;
            end
            if (pick < 0) break;
`ifdef UART_ARB_SRCTAG_EN
            t.tag  = 1'b1;
            t.id   = IDW'(pick);
            t.data = {4'hA, 1'b0, 3'(pick)};
            exp_q.push_back(t);
`endif
            cnt  = 0;
            done = 1'b0;
            while (!done && mdl_rd[pick] < src_wr[pick]) begin
                e = src_mem[pick][mdl_rd[pick]];
                mdl_rd[pick]++;
                cnt++;
                t.tag  = 1'b0;
                t.id   = IDW'(pick);
                t.data = e[7:0];
                exp_q.push_back(t);
                if (e[8] || (MB != 0 && cnt == MB)) done = 1'b1;
            end
            if (!done) break;
            m_rr = (pick + 1) % N;
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tx_busy && src_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: still busy after %0d cycles, %0d bytes outstanding, expected 0",
                     name, max_cyc, exp_q.size());
        end
    endtask

    // Requester queues and core model, updated just after each rising edge.
    initial begin
        rst_seen = 1'b1;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            rst_seen = !nrst;
            #1;
            if (rst_seen) begin
                busy_cnt = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (xfer_mask[i]) src_rd[i]++;
                end
                if (start_seen) busy_cnt = busy_len;
                else if (busy_cnt > 0) busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
            for (int i = 0; i < N; i++) begin
                logic [8:0] h;
                h = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 9'h000;
                req_valid[i] = (src_rd[i] < src_wr[i]) && !hold[i];
                req_data[8*i +: 8] = h[7:0];
                req_last[i] = h[8];
            end
        end
    end

    // Per-cycle compare against the model and the reset values.
    initial begin
        ent_t e;
        ent_t g;
        logic [N-1:0] own;
        n_starts   = 0;
        last_tx    = 8'h00;
        xfer_mask  = '0;
        start_seen = 1'b0;
        forever begin
            @(negedge clk);
            xfer_mask  = req_valid & req_ready;
            start_seen = tx_start;
            if (rst_seen) begin
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_tx_start", 32'(tx_start), 0);
                chk("rst_tx_data", 32'(tx_data), 0);
                chk("rst_grant_valid", 32'(grant_valid), 0);
                chk("rst_grant_id", 32'(grant_id), 0);
                chk("rst_busy", 32'(busy), 0);
                last_tx = 8'h00;
            end else begin
                own = '0;
                if (grant_valid) own[grant_id] = 1'b1;
                chk("ready_owner_only", 32'(req_ready & ~own), 0);
                chk("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
                chk("busy_vs_grant", 32'(busy), 32'(grant_valid));
                if (tx_start) begin
                    n_starts++;
                    chk("start_core_idle", 32'(tx_busy), 0);
                    g.tag  = 1'b0;
                    g.id   = grant_id;
                    g.data = tx_data;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_start: got data %02h id %0d, expected no start",
                                 tx_data, grant_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.data));
                        chk("tx_grant_id", 32'(grant_id), 32'(e.id));
                        if (!e.tag) dlog.push_back(g);
                    end
                    flog.push_back(g);
                    last_tx = tx_data;
                end else if (tx_busy) begin
                    chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int s0;
        bit seen;
        nrst     = 1'b0;
        hold     = '0;
        busy_len = 20;
        m_rr     = 0;
        checks   = 0;
        errors   = 0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            mdl_rd[i] = 0;
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // T1: single requester, slow core, latency of the first byte
        busy_len = 1250;
        b = dlog.size();
        load(0, 8'h53, 1'b0);
        load(0, 8'h6E, 1'b0);
        load(0, 8'h61, 1'b1);
        model_run();
        @(negedge clk);
        chk("t1_ready_before", 32'(req_ready), 0);
        @(negedge clk);
`ifndef UART_ARB_SRCTAG_EN
        chk("t1_ready_latency", 32'(req_ready), 32'h1);
`endif
        @(negedge clk);
        chk("t1_start_latency", 32'(tx_start), 1);
        drain("t1", 8000);
        chk("t1_count", dlog.size() - b, 3);
        lit("t1_b0", b + 0, 0, 8'h53);
        lit("t1_b1", b + 1, 0, 8'h6E);
        lit("t1_b2", b + 2, 0, 8'h61);
        chk("t1_released", 32'(grant_valid), 0);

        // T2: all four requesters, three 1-byte packets each; rr_ptr is 1
        busy_len = 20;
        b = dlog.size();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < N; r++) load(r, 8'(16 * r + p), 1'b1);
        end
        model_run();
        drain("t2", 3000);
        chk("t2_count", dlog.size() - b, 12);
        for (int k = 0; k < 12; k++) lit("t2_order", b + k, (1 + k) % N, 16 * ((1 + k) % N) + k / 4);

        // T3: burst limit; requester 1 streams 40 bytes, requester 2 sends a
        // 16-byte packet whose last byte also hits the limit
        b = dlog.size();
        for (int j = 0; j < 40; j++) load(1, 8'(8'h80 + j), (j == 39) ? 1'b1 : 1'b0);
        for (int j = 0; j < 16; j++) load(2, 8'(8'h20 + j), (j == 15) ? 1'b1 : 1'b0);
        model_run();
        drain("t3", 6000);
        chk("t3_count", dlog.size() - b, 56);
        lit("t3_first", b + 0, 1, 8'h80);
        lit("t3_burst_end", b + 15, 1, 8'h8F);
        lit("t3_switch", b + 16, 2, 8'h20);
        lit("t3_r2_end", b + 31, 2, 8'h2F);
        lit("t3_resume", b + 32, 1, 8'h90);
        lit("t3_third", b + 48, 1, 8'hA0);
        lit("t3_last", b + 55, 1, 8'hA7);

        // T4: owner (requester 2) pauses for 100 cycles while requester 3 waits
        b = dlog.size();
        for (int j = 0; j < 4; j++) load(2, 8'(8'hC0 + j), (j == 3) ? 1'b1 : 1'b0);
        load(3, 8'hD0, 1'b1);
        model_run();
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (src_rd[2] >= src_wr[2] - 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_two_sent", 32'(seen), 1);
        hold[2] = 1'b1;
        @(negedge clk);
        s0 = n_starts;
        repeat (100) @(negedge clk);
        chk("t4_no_start_in_gap", n_starts - s0, 0);
        chk("t4_grant_held", 32'(grant_valid), 1);
        chk("t4_grant_id", 32'(grant_id), 2);
        chk("t4_ready_idle", 32'(req_ready), 0);
        hold[2] = 1'b0;
        drain("t4", 2000);
        lit("t4_b0", b + 0, 2, 8'hC0);
        lit("t4_b3", b + 3, 2, 8'hC3);
        lit("t4_next", b + 4, 3, 8'hD0);

        // T5: reset while waiting on the core
        s0 = n_starts;
        load(0, 8'h11, 1'b0);
        load(0, 8'h22, 1'b1);
        model_run();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (n_starts > s0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_first_start", 32'(seen), 1);
        @(negedge clk);
        nrst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = src_wr[i];
            mdl_rd[i] = src_wr[i];
        end
        exp_q.delete();
        m_rr = 0;
        @(negedge clk);
        nrst = 1'b1;
        s0 = n_starts;
        repeat (50) @(negedge clk);
        chk("t5_quiet_after_reset", n_starts - s0, 0);
        chk("t5_idle_after_reset", 32'(busy), 0);
        b = dlog.size();
        load(1, 8'h31, 1'b1);
        load(0, 8'h30, 1'b1);
        model_run();
        drain("t5", 1000);
        lit("t5_rr_reset", b + 0, 0, 8'h30);
        lit("t5_rr_next", b + 1, 1, 8'h31);

`ifdef UART_ARB_SRCTAG_EN
        // T6: source header before the data byte
        load(2, 8'h70, 1'b1);
        model_run();
        drain("t6", 1000);
        if (flog.size() >= 2) begin
            chk("t6_header", 32'(flog[flog.size() - 2].data), 32'h A2);
            chk("t6_data", 32'(flog[flog.size() - 1].data), 32'h70);
        end else begin
            checks++;
            errors++;
            $display("FAIL t6_sequence: got %0d starts, expected at least 2", flog.size());
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
